// File: rtl/logistic_pkg.sv
// Shared types and fixed-point constants for the logistic-map engine.
package logistic_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam int DEF_W = 16;
  localparam longint ONE = 64'd1 << DEF_W;
  localparam int MU_W = DEF_W + 2;

  localparam logic [DEF_W-1:0] DEF_SEED_BASE = 16'h8000;
  localparam logic [DEF_W-1:0] DEF_SEED_STEP = 16'h1000;

endpackage

// File: rtl/logistic_step.sv
// One combinational logistic-map step y = mu*x*(1-x), Q0.W state and Q2.W mu.
module logistic_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W+1:0] mu,
  output logic [W-1:0] y
);

  // Truncating step; x*(1-x) <= 1/4 keeps mu*term below 2^W, so no saturation.
  function automatic logic [W-1:0] step_trunc(input logic [W-1:0] xv, input logic [W+1:0] mv);
    logic [W:0]     comp;
    logic [2*W:0]   term;
    logic [W-1:0]   term_hi;
    logic [2*W+1:0] prod;
    comp    = {1'b1, {W{1'b0}}} - {1'b0, xv};
    term    = (2*W+1)'(xv) * (2*W+1)'(comp);
    term_hi = W'(term >> W);
    prod    = (2*W+2)'(mv) * (2*W+2)'(term_hi);
    return W'(prod >> W);
  endfunction

  assign y = step_trunc(x, mu);

endmodule

// File: rtl/logistic_bank.sv
// N_CH logistic-map orbits iterated round-robin over one shared step datapath.
module logistic_bank
  import logistic_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int N_CH   = 4,
  parameter int ITER_W = 10,
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ITER_W-1:0] iters,
  input  logic [W+1:0]      mu,
  input  logic [W-1:0]      seed_base,
  input  logic [W-1:0]      seed_step,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [W-1:0]      out_data,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [W-1:0]      rd_data
);

  state_t            state, state_nxt;
  logic [W+1:0]      mu_q;
  logic [ITER_W-1:0] iters_q;
  logic [ITER_W-1:0] round;
  logic [CH_W-1:0]   ch_ptr;
  logic [W-1:0]      x [N_CH];
  logic [W-1:0]      x_cur;
  logic [W-1:0]      y;
  logic              last_ch;
  logic              last_upd;

  assign x_cur    = x[ch_ptr];
  assign last_ch  = (int'(ch_ptr) == N_CH - 1);
  assign last_upd = (state == RUN) && last_ch && (round == iters_q - ITER_W'(1));

  logistic_step #(.W(W)) u_step (
    .x  (x_cur),
    .mu (mu_q),
    .y  (y)
  );

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: state_nxt = (iters != '0) ? RUN : DONE;
      RUN:  if (last_upd) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      mu_q      <= '0;
      iters_q   <= '0;
      round     <= '0;
      ch_ptr    <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      rd_data   <= '0;
      for (int c = 0; c < N_CH; c++) x[c] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        LOAD: begin
          mu_q    <= mu;
          iters_q <= iters;
          round   <= '0;
          ch_ptr  <= '0;
          for (int c = 0; c < N_CH; c++) x[c] <= seed_base + W'(c) * seed_step;
        end
        // Update one channel per cycle; the stream beat lands one cycle later.
        RUN: begin
          x[ch_ptr] <= y;
          out_valid <= 1'b1;
          out_ch    <= ch_ptr;
          out_data  <= y;
          if (last_ch) begin
            ch_ptr <= '0;
            round  <= round + ITER_W'(1);
          end else begin
            ch_ptr <= ch_ptr + CH_W'(1);
          end
        end
        default: ;
      endcase
      rd_data <= (int'(rd_ch) < N_CH) ? x[rd_ch] : '0;
    end
  end

endmodule

// File: tb/tb_logistic_bank.sv
// Directed self-checking bench for logistic_bank with a bit-exact step model.
module tb_logistic_bank;
  import logistic_pkg::*;

  logic             CLK = 1'b0;
  logic             RST;
  logic             start;
  logic [9:0]       iters;
  logic [MU_W-1:0]  mu;
  logic [15:0]      seed_base;
  logic [15:0]      seed_step;
  logic             busy;
  logic             done;
  logic             out_valid;
  logic [1:0]       out_ch;
  logic [15:0]      out_data;
  logic [1:0]       rd_ch;
  logic [15:0]      rd_data;

  int tests = 0;
  int fails = 0;

  logic [1:0]  bch  [64];
  logic [15:0] bdat [64];

  logistic_bank dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .iters     (iters),
    .mu        (mu),
    .seed_base (seed_base),
    .seed_step (seed_step),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .rd_ch     (rd_ch),
    .rd_data   (rd_data)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] xv, input logic [17:0] mv);
    longint t;
    longint p;
    logic [63:0] pv;
    t  = (longint'(xv) * (65536 - longint'(xv))) >>> 16;
    p  = (longint'(mv) * t) >>> 16;
    pv = p;
    return pv[15:0];
  endfunction

  // Launches one run and records stream beats; comparisons live in the callers.
  task automatic run(input logic [17:0] m, input logic [9:0] it, input logic [15:0] sb,
                     input logic [15:0] ss, output int dcyc, output int nb, output logic dafter);
    mu = m; iters = it; seed_base = sb; seed_step = ss;
    start = 1'b1;
    tick();
    start = 1'b0;
    nb = 0;
    dcyc = -1;
    for (int c = 1; c <= 400; c++) begin
      if (out_valid) begin
        if (nb < 64) begin
          bch[nb]  = out_ch;
          bdat[nb] = out_data;
        end
        nb++;
      end
      if (done) begin
        dcyc = c;
        break;
      end
      tick();
    end
    tick();
    dafter = done;
  endtask

  task automatic rd(input logic [1:0] c, output logic [15:0] v);
    rd_ch = c;
    tick();
    v = rd_data;
  endtask

  task automatic test_reset();
    RST = 1'b0; start = 1'b1;
    repeat (3) tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
    tests++; if (rd_data !== 16'h0) begin fails++; $display("FAIL reset_rd got %h want 0", rd_data); end
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_no_load got busy %b want 0", busy); end
    start = 1'b0; RST = 1'b1;
    tick();
  endtask

  task automatic test_fixed_point();
    int dc, nb; logic da; logic [15:0] v;
    run(18'(2 * ONE), 10'd3, DEF_SEED_BASE, 16'h0, dc, nb, da);
    tests++; if (dc !== 14) begin fails++; $display("FAIL fp_latency got %0d want 14", dc); end
    tests++; if (nb !== 12) begin fails++; $display("FAIL fp_beats got %0d want 12", nb); end
    for (int i = 0; i < 12 && i < nb; i++) begin
      tests++;
      if (bch[i] !== 2'(i % 4) || bdat[i] !== 16'h8000) begin
        fails++; $display("FAIL fp_beat%0d got ch%0d %h want ch%0d 8000", i, bch[i], bdat[i], i % 4);
      end
    end
    tests++; if (da !== 1'b0) begin fails++; $display("FAIL fp_done_pulse got %b want 0", da); end
    rd(2'd2, v);
    tests++; if (v !== 16'h8000) begin fails++; $display("FAIL fp_rd2 got %h want 8000", v); end
  endtask

  task automatic test_known_orbit();
    int dc, nb; logic da; logic [15:0] v;
    logic [15:0] xm [4];
    for (int c = 0; c < 4; c++) xm[c] = DEF_SEED_BASE + 16'(c) * DEF_SEED_STEP;
    run(18'(ONE), 10'd2, DEF_SEED_BASE, DEF_SEED_STEP, dc, nb, da);
    tests++; if (dc !== 10) begin fails++; $display("FAIL ko_latency got %0d want 10", dc); end
    tests++; if (nb !== 8) begin fails++; $display("FAIL ko_beats got %0d want 8", nb); end
    tests++; if (bdat[0] !== 16'h4000) begin fails++; $display("FAIL ko_ch0_r0 got %h want 4000", bdat[0]); end
    tests++; if (bdat[4] !== 16'h3000) begin fails++; $display("FAIL ko_ch0_r1 got %h want 3000", bdat[4]); end
    tests++; if (bdat[1] !== 16'h3F00) begin fails++; $display("FAIL ko_ch1_r0 got %h want 3f00", bdat[1]); end
    for (int i = 0; i < 8 && i < nb; i++) begin
      xm[i % 4] = ref_step(xm[i % 4], 18'(ONE));
      tests++;
      if (bch[i] !== 2'(i % 4) || bdat[i] !== xm[i % 4]) begin
        fails++; $display("FAIL ko_beat%0d got ch%0d %h want ch%0d %h", i, bch[i], bdat[i], i % 4, xm[i % 4]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      rd(2'(c), v);
      tests++; if (v !== xm[c]) begin fails++; $display("FAIL ko_rd%0d got %h want %h", c, v, xm[c]); end
    end
  endtask

  task automatic test_max_mu();
    int dc, nb; logic da;
    run(18'h3FFFF, 10'd1, 16'h8000, 16'h0, dc, nb, da);
    tests++; if (nb !== 4) begin fails++; $display("FAIL mm_beats got %0d want 4", nb); end
    tests++; if (bch[0] !== 2'd0 || bdat[0] !== 16'hFFFF) begin
      fails++; $display("FAIL mm_ch0 got ch%0d %h want ch0 ffff", bch[0], bdat[0]);
    end
    run(18'h3FFFF, 10'd3, 16'h0, 16'h0, dc, nb, da);
    tests++; if (nb !== 12) begin fails++; $display("FAIL zero_seed_beats got %0d want 12", nb); end
    for (int i = 0; i < 12 && i < nb; i++) begin
      tests++; if (bdat[i] !== 16'h0) begin fails++; $display("FAIL zero_seed_beat%0d got %h want 0", i, bdat[i]); end
    end
  endtask

  task automatic test_zero_iters();
    int dc, nb; logic da; logic [15:0] v;
    logic [15:0] want [4] = '{16'h1000, 16'h3000, 16'h5000, 16'h7000};
    run(18'(ONE), 10'd0, 16'h1000, 16'h2000, dc, nb, da);
    tests++; if (dc !== 2) begin fails++; $display("FAIL zi_latency got %0d want 2", dc); end
    tests++; if (nb !== 0) begin fails++; $display("FAIL zi_beats got %0d want 0", nb); end
    for (int c = 0; c < 4; c++) begin
      rd(2'(c), v);
      tests++; if (v !== want[c]) begin fails++; $display("FAIL zi_rd%0d got %h want %h", c, v, want[c]); end
    end
  endtask

  // Start pulses and input changes during RUN must not disturb the run.
  task automatic test_overlap();
    int dc; logic [15:0] v;
    logic [15:0] xm [4];
    for (int c = 0; c < 4; c++) xm[c] = 16'h8000 + 16'(c) * 16'h1000;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) xm[c] = ref_step(xm[c], 18'h10000);
    mu = 18'h10000; iters = 10'd2; seed_base = 16'h8000; seed_step = 16'h1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    mu = 18'h3FFFF; iters = 10'd7; seed_base = 16'h1234; seed_step = 16'h0101;
    dc = -1;
    for (int c = 2; c <= 200; c++) begin
      start = (c == 3 || c == 5);
      if (done) begin dc = c; break; end
      tick();
    end
    start = 1'b0;
    tests++; if (dc !== 10) begin fails++; $display("FAIL ov_latency got %0d want 10", dc); end
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ov_requeued got busy %b want 0", busy); end
    for (int c = 0; c < 4; c++) begin
      rd(2'(c), v);
      tests++; if (v !== xm[c]) begin fails++; $display("FAIL ov_rd%0d got %h want %h", c, v, xm[c]); end
    end
  endtask

  task automatic test_abort();
    int dc, nb, ndone; logic da; logic [15:0] v;
    logic [15:0] xm [4];
    mu = 18'h10000; iters = 10'd5; seed_base = 16'h8000; seed_step = 16'h1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    RST = 1'b0;
    tick();
    tests++; if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL abort_ctrl got busy%b done%b vld%b want 000", busy, done, out_valid);
    end
    tests++; if (out_data !== 16'h0 || out_ch !== 2'd0 || rd_data !== 16'h0) begin
      fails++; $display("FAIL abort_data got ch%0d %h rd %h want 0", out_ch, out_data, rd_data);
    end
    RST = 1'b1;
    ndone = 0;
    rd_ch = 2'd1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) ndone++;
    end
    tests++; if (ndone !== 0 || rd_data !== 16'h0) begin
      fails++; $display("FAIL abort_after got %0d done pulses rd %h want 0 0", ndone, rd_data);
    end
    for (int c = 0; c < 4; c++) xm[c] = 16'h8000 + 16'(c) * 16'h1000;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) xm[c] = ref_step(xm[c], 18'h2C000);
    run(18'h2C000, 10'd3, 16'h8000, 16'h1000, dc, nb, da);
    tests++; if (dc !== 14 || nb !== 12) begin fails++; $display("FAIL abort_rerun got cyc %0d beats %0d want 14 12", dc, nb); end
    for (int c = 0; c < 4; c++) begin
      rd(2'(c), v);
      tests++; if (v !== xm[c]) begin fails++; $display("FAIL abort_rd%0d got %h want %h", c, v, xm[c]); end
    end
  endtask

  initial begin
    RST = 1'b0; start = 1'b0; iters = '0; mu = '0;
    seed_base = '0; seed_step = '0; rd_ch = '0;
    test_reset();
    test_fixed_point();
    test_known_orbit();
    test_max_mu();
    test_zero_iters();
    test_overlap();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/logistic_bank.md
Name: logistic_bank

Overview:
- Parametrised multi-channel logistic-map engine: x(n+1) = mu * x(n) * (1 - x(n)), unsigned fixed point.
- Iterates N_CH independent orbits over one shared, time-multiplexed step datapath, under a start/busy/done handshake.
- Seed spacing is programmable; every update is streamed out; final states are readable through a registered read port.
- Feeds the chaos-map display/plot logic, which consumes both the update stream and the final per-channel values.

Parameters:
- W, 16, fractional width; x is Q0.W in [0,1).
- N_CH, 4, number of channels (>=1).
- ITER_W, 10, width of the iteration-count input.
- CH_W, $clog2(N_CH) (min 1), width of channel indices.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-low
- start  in  1  run request, sampled only in IDLE
- iters  in  ITER_W  full rounds to run (each channel mapped iters times)
- mu  in  W+2  Q2.W parameter, [0,4)
- seed_base  in  W  seed of channel 0
- seed_step  in  W  seed increment per channel
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- out_valid  out  1  update-stream valid
- out_ch  out  CH_W  channel of the streamed update
- out_data  out  W  new x value of that channel
- rd_ch  in  CH_W  read-port channel select
- rd_data  out  W  x[rd_ch], registered

Behaviour:
- Reset (RST=0 at a CLK edge): state IDLE; all x[c], ch_ptr, round counter, busy, done, out_valid, out_ch, out_data, rd_data = 0. Reset mid-run aborts the run; no done pulse is produced.
- States:
  - IDLE: start=1 -> LOAD; otherwise stay.
  - LOAD: one cycle. Latch mu, iters. x[c] <= seed_base + c*seed_step, mod 2^W. ch_ptr=0, round=0. Next state RUN if iters!=0, else DONE.
  - RUN: each cycle x[ch_ptr] <= step(x[ch_ptr]).
    - ch_ptr advances 0..N_CH-1, then wraps to 0 and round++.
    - After the update of ch_ptr=N_CH-1 with round=iters-1, next state DONE.
    - RUN lasts exactly N_CH*iters cycles.
  - DONE: done=1 for this cycle only; next state IDLE.
- Latency: start sampled high at edge t -> done high in cycle t+2+N_CH*iters.
- Inputs during a run:
  - start while busy is ignored, not queued.
  - mu, iters, seed_base and seed_step changes after LOAD do not affect the current run.
- Arithmetic (step), no overflow possible:
  - term = x*(2^W - x), 2W+1 bits wide; keep term>>W (W bits, max 2^(W-2)).
  - prod = mu*(term>>W); y = prod>>W, truncated.
  - Upper bits of y are provably 0; y is taken as W bits. x=0 yields y=0.
- Stream:
  - The cycle after each RUN update: out_valid=1, out_ch = the channel just updated, out_data = its new value.
  - out_valid=0 otherwise, including LOAD and the cycle after LOAD.
  - The last stream beat coincides with the DONE cycle.
- Read port:
  - rd_data <= x[rd_ch] every cycle (1-cycle latency), independent of state.
  - During RUN it returns the in-progress value. rd_ch >= N_CH returns 0.
  - Values hold after DONE until the next LOAD.

Decomposition:
- Package logistic_pkg holds:
  - state enum {IDLE, LOAD, RUN, DONE};
  - fixed-point helper constants: ONE = 2^W, MU_W = W+2;
  - default seed constants.
- Sub-module logistic_step: purely combinational single step (x, mu -> y), parametrised by W. It is instantiated once and shared across channels via the ch_ptr mux.

Test Plan:
- Reset/idle: hold RST=0 3 cycles -> busy=0, done=0, out_valid=0, rd_data=0; start while RST=0 -> no LOAD.
- Fixed point: N_CH=4, mu=0x20000, seed_base=0x8000, seed_step=0, iters=3.
  - Stream shows 12 beats of 0x8000 on ch 0,1,2,3 repeating.
  - done at t+2+12; rd_ch=2 -> 0x8000.
- Known orbit: mu=0x10000, seed_base=0x8000, seed_step=0x1000, iters=2.
  - ch0 beats 0x4000 then 0x3000; ch1 (seed 0x9000) first beat 0x3F00.
  - All values match a reference model bit-exactly.
- Max mu: mu=0x3FFFF, seed 0x8000, iters=1 -> ch0 out_data=0xFFFF, no wrap.
  - Seed 0 -> output 0 forever.
- Zero iters and overlap:
  - iters=0 -> done at t+2, no out_valid, rd_data = the seeds.
  - start pulsed during RUN -> ignored, cycle count unchanged.
  - mu changed mid-run -> results unchanged.
- Abort: RST=0 mid-RUN -> next cycle all outputs 0, no done pulse.
  - A fresh start then runs to completion with correct results.
